// File: rtl/muldiv_seq.sv
// Sequential multiply / multiply-accumulate / unsigned and signed divide unit.
// One shift-add or restoring-divide step per cycle; result registered in FINISH.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] rem_out,
  output logic             divzero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  typedef enum logic [1:0] {OP_MUL = 2'b00, OP_MLA = 2'b01, OP_UDIV = 2'b10, OP_SDIV = 2'b11} op_t;

  state_t           state_q, state_d;
  op_t              op_in, op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;     // partial product, or running remainder
  logic [WIDTH-1:0] mq_q;      // multiplier shifting out, or dividend/quotient
  logic [WIDTH-1:0] opnd_q;    // multiplicand shifting left, or divisor magnitude
  logic [WIDTH-1:0] addend_q;
  logic             neg_quo_q, neg_rem_q, dz_q;

  logic             accept, b_zero, in_div;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, rem_diff;
  logic [WIDTH-1:0] prod_sum;
  logic [WIDTH-1:0] res_fin, rem_fin;

  assign op_in  = op_t'(op);
  assign in_div = op[1];
  assign b_zero = (b == '0);

  // Signed divide works on magnitudes; the most-negative value maps onto itself,
  // which as an unsigned magnitude is exactly right.
  assign a_neg = (op_in == OP_SDIV) && a[WIDTH-1];
  assign b_neg = (op_in == OP_SDIV) && b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Restoring step: the remainder is always below the divisor, so WIDTH+1 bits suffice.
  assign rem_sh   = {acc_q, mq_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, opnd_q};
  assign prod_sum = acc_q + (mq_q[0] ? opnd_q : '0);

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (in_div && b_zero) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (abort)                   state_d = IDLE;
        else if (cnt_q == CW'(1))    state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res_fin = mq_q;
    rem_fin = acc_q;
    if (dz_q) begin
      res_fin = '0;
      rem_fin = mq_q;
    end else begin
      unique case (op_q)
        OP_MUL: begin
          res_fin = acc_q;
          rem_fin = '0;
        end
        OP_MLA: begin
          res_fin = acc_q + addend_q;
          rem_fin = '0;
        end
        OP_UDIV: begin
          res_fin = mq_q;
          rem_fin = acc_q;
        end
        OP_SDIV: begin
          res_fin = neg_quo_q ? -mq_q : mq_q;
          rem_fin = neg_rem_q ? -acc_q : acc_q;
        end
        default: ;
      endcase
    end
  end

  // NOTE: datapath registers are reset too, so a reset mid-operation leaves no
  // stale operand or partial result behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= OP_MUL;
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      opnd_q    <= '0;
      addend_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else if (accept) begin
      op_q      <= op_in;
      cnt_q     <= CW'(WIDTH);
      acc_q     <= '0;
      addend_q  <= c;
      dz_q      <= in_div && b_zero;
      neg_quo_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      if (in_div) begin
        // On divide-by-zero the raw dividend is kept so it can be returned as remainder.
        mq_q   <= b_zero ? a : a_mag;
        opnd_q <= b_mag;
      end else begin
        mq_q   <= b;
        opnd_q <= a;
      end
    end else if (state_q == RUN && !abort) begin
      cnt_q <= cnt_q - CW'(1);
      if (op_q[1]) begin
        if (!rem_diff[WIDTH]) begin
          acc_q <= rem_diff[WIDTH-1:0];
          mq_q  <= {mq_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_q <= rem_sh[WIDTH-1:0];
          mq_q  <= {mq_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_q  <= prod_sum;
        opnd_q <= opnd_q << 1;
        mq_q   <= mq_q >> 1;
      end
    end
  end

  // Outputs change only on an unaborted FINISH, so they hold between operations.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done    <= 1'b0;
      result  <= '0;
      rem_out <= '0;
      divzero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == FINISH && !abort) begin
        done    <= 1'b1;
        result  <= res_fin;
        rem_out <= rem_fin;
        divzero <= dz_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq at WIDTH=32.
// Inputs change at #1 after a rising edge or on the falling edge; outputs are sampled at #1.
module tb_muldiv_seq;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b, c;
  logic         abort;
  logic         busy, done, divzero;
  logic [W-1:0] result, rem_out;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .c(c), .abort(abort),
    .busy(busy), .done(done), .result(result), .rem_out(rem_out), .divzero(divzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive a request for one edge; after acceptance the operand inputs are scrambled.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] cv, input logic ab);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv; c = cv; abort = ab;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h0000_0003; c = 32'h1234_5678; op = 2'b10;
  endtask

  // Count edges from the current sample point until done, bounded.
  task automatic wait_done(input string tag, output int lat, output int bcnt);
    bit got = 0;
    lat = 0;
    bcnt = 0;
    check({tag, "_done_low_at_start"}, {31'd0, done}, 32'd0);
    while (!got && lat < 200) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
      if (done) got = 1;
    end
    if (!got) check({tag, "_timeout"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_low_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] cv,
                        input logic [W-1:0] exp_res, input logic [W-1:0] exp_rem,
                        input logic exp_dz, input int exp_lat);
    int lat, bcnt;
    issue(o, av, bv, cv, 1'b0);
    wait_done(tag, lat, bcnt);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, bcnt, exp_lat);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_rem"}, rem_out, exp_rem);
    check({tag, "_divzero"}, {31'd0, divzero}, {31'd0, exp_dz});
  endtask

  int lat, bcnt, pulses;

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; c = '0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rem", rem_out, 32'd0);
    check("reset_divzero", {31'd0, divzero}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 32'd0, 1'b0, 33);
    run_op("mla_wrap", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'd5, 32'h0000_0003, 32'd0, 1'b0, 33);
    run_op("mul_ones", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h0000_0001, 32'd0, 1'b0, 33);
    run_op("sdiv_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("sdiv_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    run_op("sdiv_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd0, 1'b0, 33);
    run_op("udiv_5_0", 2'b10, 32'd5, 32'd0, 32'd0, 32'd0, 32'd5, 1'b1, 1);
    run_op("udiv_100_7", 2'b10, 32'd100, 32'd7, 32'd0, 32'd14, 32'd2, 1'b0, 33);
    run_op("udiv_big", 2'b10, 32'hFFFF_FFFF, 32'h10, 32'd0, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0, 33);
    run_op("sdiv_m9_0", 2'b11, 32'hFFFF_FFF7, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFF7, 1'b1, 1);

    // A second start five cycles into a multiply is ignored.
    issue(2'b00, 32'd3, 32'd5, 32'd0, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd77; b = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignored_start", lat, bcnt);
    check("ignored_start_latency", 6 + lat, 33);
    check("ignored_start_result", result, 32'd15);
    check("ignored_start_rem", rem_out, 32'd0);
    check("ignored_start_divzero", {31'd0, divzero}, 32'd0);

    // Abort at cycle 10: back to idle, no done, outputs keep the previous result.
    issue(2'b00, 32'd9, 32'd9, 32'd0, 1'b0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result_held", result, 32'd15);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);

    // Abort while idle does not block a start in the same cycle.
    issue(2'b10, 32'd100, 32'd7, 32'd0, 1'b1);
    check("idle_abort_accepts", {31'd0, busy}, 32'd1);
    wait_done("idle_abort", lat, bcnt);
    check("idle_abort_latency", lat, 33);
    check("idle_abort_result", result, 32'd14);

    // Reset in the middle of a divide.
    issue(2'b10, 32'd1000, 32'd3, 32'd0, 1'b0);
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    #1;
    reset = 1'b0;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_result", result, 32'd0);
    check("midreset_rem", rem_out, 32'd0);
    check("midreset_divzero", {31'd0, divzero}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    check("midreset_no_done", pulses, 0);

    run_op("after_reset", 2'b10, 32'd1000, 32'd3, 32'd0, 32'd333, 32'd1, 1'b0, 33);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
